// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter for the 6-digit display path.
// Latency: WIDTH+1 cycles from the accepting edge to the done pulse.
// Backpressure: none. start is ignored while busy; digit outputs hold between conversions.
module bin2bcd_seq #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       out0,
  output logic [3:0]       out1,
  output logic [3:0]       out2,
  output logic [3:0]       out3,
  output logic [3:0]       out4,
  output logic [3:0]       out5
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [27:0]      scratch;   // 7 digits so values up to 2^20-1 survive for the overflow test
  logic [CW-1:0]    cnt;
  logic [27:0]      adj;

  // Double-dabble correction: every digit >= 5 gets +3 before the shift
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 7; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM with registered outputs; digits only update at FINISH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      out0    <= 4'd0;
      out1    <= 4'd0;
      out2    <= 4'd0;
      out3    <= 4'd0;
      out4    <= 4'd0;
      out5    <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= in;
            scratch <= '0;
            cnt     <= CW'(WIDTH - 1);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= {adj[26:0], shreg[WIDTH-1]};
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          if (cnt == '0) begin
            state <= FINISH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FINISH: begin
          if (scratch[27:24] != 4'd0) begin
            // Above 999999: saturate the display rather than show a truncated value
            out0 <= 4'd9;
            out1 <= 4'd9;
            out2 <= 4'd9;
            out3 <= 4'd9;
            out4 <= 4'd9;
            out5 <= 4'd9;
            ovf  <= 1'b1;
          end else begin
            out0 <= scratch[23:20];
            out1 <= scratch[19:16];
            out2 <= scratch[15:12];
            out3 <= scratch[11:8];
            out4 <= scratch[7:4];
            out5 <= scratch[3:0];
            ovf  <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed table, corner sequences, random sweep.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
// Every wait on done is bounded; a missing pulse counts as a failure.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [19:0] din;
  logic        busy;
  logic        done;
  logic        ovf;
  logic [3:0]  o0, o1, o2, o3, o4, o5;
  logic [23:0] outs;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [19:0] val;
    logic [23:0] bcd;
    logic        ov;
  } vec_t;

  vec_t tbl[6];

  bin2bcd_seq #(.WIDTH(20)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (din),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf),
    .out0  (o0),
    .out1  (o1),
    .out2  (o2),
    .out3  (o3),
    .out4  (o4),
    .out5  (o5)
  );

  assign outs = {o0, o1, o2, o3, o4, o5};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Independent reference: decimal split, saturated above 999999
  function automatic logic [23:0] ref_bcd(input int v);
    logic [23:0] r;
    r = '0;
    if (v > 999999) begin
      r = 24'h999999;
    end else begin
      for (int i = 0; i < 6; i++) begin
        r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
      end
    end
    return r;
  endfunction

  // Called 1 unit after the accepting edge; returns cycles until done (0 = timeout)
  task automatic wait_done(input bit toggle, output int lat, output bit stable, output int busy_cycles);
    logic [23:0] h;
    logic        ho;
    h = outs;
    ho = ovf;
    lat = 0;
    stable = 1'b1;
    busy_cycles = 0;
    for (int k = 1; k <= 40; k++) begin
      if (toggle) din = 20'($urandom);
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cycles++;
      if (outs !== h || ovf !== ho) stable = 1'b0;
    end
  endtask

  // Called 1 unit after an edge with the DUT in IDLE
  task automatic run_conv(input logic [19:0] v, input logic [23:0] exp_d, input logic exp_o,
                          input bit toggle, input string nm);
    int lat;
    bit stable;
    int bc;
    start = 1'b1;
    din = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({nm, " busy after accept"}, 32'(busy), 32'd1);
    wait_done(toggle, lat, stable, bc);
    check({nm, " latency"}, 32'(lat), 32'd21);
    check({nm, " busy cycles"}, 32'(bc), 32'd20);
    check({nm, " outputs stable while busy"}, 32'(stable), 32'd1);
    check({nm, " digits"}, 32'(outs), 32'(exp_d));
    check({nm, " ovf"}, 32'(ovf), 32'(exp_o));
    check({nm, " busy low at done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    bit stable;
    int bc;
    bit seen_done;
    bit seen_busy;
    int v;

    tbl[0] = '{20'd0,       24'h000000, 1'b0};
    tbl[1] = '{20'd123456,  24'h123456, 1'b0};
    tbl[2] = '{20'd999999,  24'h999999, 1'b0};
    tbl[3] = '{20'd1000,    24'h001000, 1'b0};
    tbl[4] = '{20'd1048575, 24'h999999, 1'b1};
    tbl[5] = '{20'd42,      24'h000042, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    din = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    check("reset digits", 32'(outs), 32'd0);

    // Directed table, issued back to back (each start lands in the previous done cycle)
    for (int i = 0; i < 6; i++) begin
      run_conv(tbl[i].val, tbl[i].bcd, tbl[i].ov, 1'b0, $sformatf("vec%0d", i));
    end
    @(posedge clk);
    #1;
    check("done single cycle", 32'(done), 32'd0);

    // Starts while busy are ignored; start in the done cycle is accepted
    start = 1'b1;
    din = 20'd123456;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen_done = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      start = (k == 5 || k == 21);
      if (k == 5 || k == 21) din = 20'd777;
      @(posedge clk);
      #1;
      if (done && k != 21) seen_done = 1'b1;
    end
    check("ignore: early done", 32'(seen_done), 32'd0);
    check("ignore: done at 21", 32'(done), 32'd1);
    check("ignore: digits", 32'(outs), 32'h123456);
    start = 1'b1;
    din = 20'd654321;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b: busy after accept", 32'(busy), 32'd1);
    wait_done(1'b0, lat, stable, bc);
    check("b2b: second done latency", 32'(lat), 32'd21);
    check("b2b: digits", 32'(outs), 32'h654321);
    check("b2b: held first result while busy", 32'(stable), 32'd1);

    // Reset mid-conversion
    @(posedge clk);
    #1;
    run_conv(20'd999999, 24'h999999, 1'b0, 1'b0, "pre-reset");
    start = 1'b1;
    din = 20'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst ovf", 32'(ovf), 32'd0);
    check("midrst digits", 32'(outs), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen_done = 1'b0;
    seen_busy = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    check("midrst no done pulse", 32'(seen_done), 32'd0);
    check("midrst stays idle", 32'(seen_busy), 32'd0);
    check("midrst digits after", 32'(outs), 32'd0);
    run_conv(20'd5, 24'h000005, 1'b0, 1'b0, "post-reset");

    // Random sweep with in toggled during busy
    for (int n = 0; n < 1000; n++) begin
      v = int'($urandom_range(0, 1048575));
      run_conv(20'(v), ref_bcd(v), (v > 999999), 1'b1, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
